fft8_bf_sched: RTL

- Sequencer for the single shared radix-2 butterfly in the 8-point FFT. It runs 3 decimation-in-time stages of 4 butterflies each, 12 operations in total.
- Each operation issues the operand read addresses, the twiddle factor (Q8.8) and the butterfly start strobe. After the butterfly latency it issues the write-back addresses, so results land in place in the 8-entry working memory.
- Input data is already in bit-reversed order in that memory; the block contains no data path for samples.

---
 rtl/fft8_bf_sched_if.sv | 32 +++
 rtl/fft8_bf_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fft8_bf_sched_if.sv
// Bus between the FFT butterfly sequencer and the datapath it steers.
// The master side is the sequencer. The slave side is the memory, butterfly
// and control logic that consume its strobes.
`timescale 1ns/1ps
interface fft8_bf_sched_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic              busy;
    logic              done;
    logic              bf_start;
    logic [2:0]        rd_addr_a;
    logic [2:0]        rd_addr_b;
    logic [DATA_W-1:0] w_r;
    logic [DATA_W-1:0] w_i;
    logic              wr_en;
    logic [2:0]        wr_addr_a;
    logic [2:0]        wr_addr_b;
    logic [1:0]        stage;

    modport master (
        input  start,
        output busy, done, bf_start, rd_addr_a, rd_addr_b, w_r, w_i,
               wr_en, wr_addr_a, wr_addr_b, stage
    );

    modport slave (
        output start,
        input  busy, done, bf_start, rd_addr_a, rd_addr_b, w_r, w_i,
               wr_en, wr_addr_a, wr_addr_b, stage
    );
endinterface

// File: rtl/fft8_bf_sched.sv
// Sequencer for the single shared radix-2 butterfly of an 8-point DIT FFT.
// It runs 3 stages of 4 butterflies each. For every operation it issues the
// read addresses and the twiddle. It then replays the addresses as write-back
// addresses BF_LAT cycles later, so the results land in place.
// All outputs are registered. They are computed from the next state, so the
// cycle after start is sampled is already the first busy/bf_start cycle.
`timescale 1ns/1ps
module fft8_bf_sched #(
    parameter int DATA_W = 16,
    parameter int BF_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    fft8_bf_sched_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

    state_t     state_q, state_d;
    logic [1:0] stage_q, stage_d;
    logic [1:0] k_q, k_d;
    logic [2:0] lat_q, lat_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bf_start_q, bf_start_d;
    logic [1:0]        stage_out_q, stage_out_d;
    logic [2:0]        rd_a_q, rd_a_d;
    logic [2:0]        rd_b_q, rd_b_d;
    logic [DATA_W-1:0] w_r_q, w_r_d;
    logic [DATA_W-1:0] w_i_q, w_i_d;

    // Write-back delay line: slot BF_LAT-1 drives the write-back outputs.
    logic       pipe_v_q [BF_LAT];
    logic [2:0] pipe_a_q [BF_LAT];
    logic [2:0] pipe_b_q [BF_LAT];
    logic       src_v    [BF_LAT];
    logic [2:0] src_a    [BF_LAT];
    logic [2:0] src_b    [BF_LAT];

    // State register: sequencing state, stage, op index and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= 2'd0;
            k_q     <= 2'd0;
            lat_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state logic: 4 issue cycles, BF_LAT drain cycles, repeat per stage
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ISSUE;
                    stage_d = 2'd0;
                    k_d     = 2'd0;
                end
            end
            S_ISSUE: begin
                if (k_q == 2'd3) begin
                    state_d = S_WAIT;
                    lat_d   = 3'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_WAIT: begin
                if (lat_q == 3'(BF_LAT - 1)) begin
                    if (stage_q == 2'd2) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 2'd1;
                        k_d     = 2'd0;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            default: begin
                // The done cycle is the run boundary. A start held high here
                // chains straight into the next run with no idle gap.
                if (bus.start) begin
                    state_d = S_ISSUE;
                    stage_d = 2'd0;
                    k_d     = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Output logic: status, DIT addresses and twiddle ROM for the coming cycle
    always_comb begin
        logic [2:0] span;
        logic [2:0] group;
        logic [2:0] pos;
        logic [1:0] tw;
        busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT);
        done_d      = (state_d == S_FIN);
        bf_start_d  = (state_d == S_ISSUE);
        stage_out_d = busy_d ? stage_d : 2'd0;
        rd_a_d      = rd_a_q;
        rd_b_d      = rd_b_q;
        w_r_d       = w_r_q;
        w_i_d       = w_i_q;
        span        = 3'd1 << stage_d;
        group       = {1'b0, k_d} >> stage_d;
        pos         = {1'b0, k_d} & (span - 3'd1);
        tw          = 2'(pos << (2'd2 - stage_d));
        if (bf_start_d) begin
            rd_a_d = 3'(group << (stage_d + 2'd1)) + pos;
            rd_b_d = 3'(group << (stage_d + 2'd1)) + pos + span;
            case (tw)
                2'd0:    begin w_r_d = DATA_W'(16'sh0100); w_i_d = DATA_W'(16'sh0000); end
                2'd1:    begin w_r_d = DATA_W'(16'sh00B5); w_i_d = DATA_W'(16'shFF4B); end
                2'd2:    begin w_r_d = DATA_W'(16'sh0000); w_i_d = DATA_W'(16'shFF00); end
                default: begin w_r_d = DATA_W'(16'shFF4B); w_i_d = DATA_W'(16'shFF4B); end
            endcase
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bf_start_q  <= 1'b0;
            stage_out_q <= 2'd0;
            rd_a_q      <= 3'd0;
            rd_b_q      <= 3'd0;
            w_r_q       <= '0;
            w_i_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            bf_start_q  <= bf_start_d;
            stage_out_q <= stage_out_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
            w_r_q       <= w_r_d;
            w_i_q       <= w_i_d;
        end
    end

    // Each delay slot is fed by the issued op (slot 0) or by the previous slot
    generate
        for (genvar gi = 0; gi < BF_LAT; gi++) begin : g_src
            if (gi == 0) begin : g_head
                assign src_v[gi] = bf_start_q;
                assign src_a[gi] = rd_a_q;
                assign src_b[gi] = rd_b_q;
            end else begin : g_tail
                assign src_v[gi] = pipe_v_q[gi-1];
                assign src_a[gi] = pipe_a_q[gi-1];
                assign src_b[gi] = pipe_b_q[gi-1];
            end
        end
    endgenerate

    // Delay line shift: addresses move only with a valid op, so they hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BF_LAT; i++) begin
                pipe_v_q[i] <= 1'b0;
                pipe_a_q[i] <= 3'd0;
                pipe_b_q[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < BF_LAT; i++) begin
                pipe_v_q[i] <= src_v[i];
                if (src_v[i]) begin
                    pipe_a_q[i] <= src_a[i];
                    pipe_b_q[i] <= src_b[i];
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bf_start  = bf_start_q;
    assign bus.stage     = stage_out_q;
    assign bus.rd_addr_a = rd_a_q;
    assign bus.rd_addr_b = rd_b_q;
    assign bus.w_r       = w_r_q;
    assign bus.w_i       = w_i_q;
    assign bus.wr_en     = pipe_v_q[BF_LAT-1];
    assign bus.wr_addr_a = pipe_a_q[BF_LAT-1];
    assign bus.wr_addr_b = pipe_b_q[BF_LAT-1];
endmodule
